pdm_modulator_4ch: RTL and testbench

//  Four-channel first-order sigma-delta PDM modulator. Consumes the four sampled PDM_VALUE_WIDTH-bit

---
 rtl/pdm_modulator_4ch_pkg.sv | 11 +
 rtl/pdm_sigma_delta_ch.sv | 61 ++++++
 rtl/pdm_modulator_4ch.sv | 85 ++++++++
 tb/tb_pdm_modulator_4ch.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pdm_modulator_4ch_pkg.sv
// Shared PDM constants, also used by the value-supply stage so channel widths agree.
//   PDM_W_DEFAULT       : default width of channel value, accumulator and frame counter
//   PDM_CLK_DIV_DEFAULT : default aclk cycles per PDM step
//   PDM_NUM_CH          : number of PDM channels
package pdm_modulator_4ch_pkg;

  localparam int unsigned PDM_W_DEFAULT       = 11;
  localparam int unsigned PDM_CLK_DIV_DEFAULT = 1;
  localparam int unsigned PDM_NUM_CH          = 4;

endpackage

// File: rtl/pdm_sigma_delta_ch.sv
// One first-order sigma-delta PDM channel.
//   aclk, aresetn : clock, async active-low reset
//   clr           : synchronous clear of all channel state
//   step          : advance the modulator by one PDM step
//   load          : with step, latch value and use it for this step (frame boundary)
//   value         : channel value, unsigned
//   pdm_bit       : registered PDM output bit (carry of the last step)
module pdm_sigma_delta_ch #(
  parameter int unsigned W = 11
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         clr,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         pdm_bit
);

  logic [W-1:0] val_q, val_d;
  logic [W-1:0] acc_q, acc_d;
  logic         bit_q, bit_d;
  logic [W-1:0] addend_c;
  logic [W:0]   sum_c;

  // Next-state: new value takes effect on the very step that latches it.
  always_comb begin
    val_d    = val_q;
    acc_d    = acc_q;
    bit_d    = bit_q;
    addend_c = load ? value : val_q;
    sum_c    = {1'b0, acc_q} + {1'b0, addend_c};
    if (step) begin
      acc_d = sum_c[W-1:0];
      bit_d = sum_c[W];
      if (load) begin
        val_d = value;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      val_q <= '0;
      acc_q <= '0;
      bit_q <= 1'b0;
    end else if (clr) begin
      val_q <= '0;
      acc_q <= '0;
      bit_q <= 1'b0;
    end else begin
      val_q <= val_d;
      acc_q <= acc_d;
      bit_q <= bit_d;
    end
  end

  assign pdm_bit = bit_q;

endmodule

// File: rtl/pdm_modulator_4ch.sv
// Four-channel first-order sigma-delta PDM modulator.
// Channel values are latched only at frame boundaries (every 2^W PDM steps).
//   aclk, aresetn        : clock, async active-low reset
//   enable               : run; low synchronously clears all state
//   pdm_channel_1..4     : W-bit unsigned channel values
//   pdm_out[3:0]         : registered PDM bit streams, bit n-1 = channel n
//   frame_start          : one-cycle pulse on the first step of each frame
module pdm_modulator_4ch
  import pdm_modulator_4ch_pkg::*;
#(
  parameter int unsigned PDM_VALUE_WIDTH = PDM_W_DEFAULT,
  parameter int unsigned CLK_DIV         = PDM_CLK_DIV_DEFAULT
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       enable,
  input  logic [PDM_VALUE_WIDTH-1:0] pdm_channel_1,
  input  logic [PDM_VALUE_WIDTH-1:0] pdm_channel_2,
  input  logic [PDM_VALUE_WIDTH-1:0] pdm_channel_3,
  input  logic [PDM_VALUE_WIDTH-1:0] pdm_channel_4,
  output logic [PDM_NUM_CH-1:0]      pdm_out,
  output logic                       frame_start
);

  localparam int unsigned W     = PDM_VALUE_WIDTH;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [W-1:0]     frame_cnt_q, frame_cnt_d;
  logic             frame_start_q;
  logic             tick_c;
  logic             load_c;
  logic             clr_c;
  logic [W-1:0]     chan_val_c [PDM_NUM_CH];
  logic [PDM_NUM_CH-1:0] pdm_bits;

  assign chan_val_c[0] = pdm_channel_1;
  assign chan_val_c[1] = pdm_channel_2;
  assign chan_val_c[2] = pdm_channel_3;
  assign chan_val_c[3] = pdm_channel_4;

  // Prescaler tick, frame-boundary load and counter next-state.
  always_comb begin
    clr_c       = !enable;
    tick_c      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    load_c      = tick_c && (frame_cnt_q == '0);
    div_cnt_d   = tick_c ? '0 : div_cnt_q + DIV_W'(1);
    frame_cnt_d = tick_c ? frame_cnt_q + W'(1) : frame_cnt_q;
  end

  // Shared timing registers; enable low behaves like reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
    end else if (clr_c) begin
      div_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= load_c;
    end
  end

  for (genvar n = 0; n < PDM_NUM_CH; n++) begin : g_ch
    pdm_sigma_delta_ch #(
      .W (W)
    ) u_ch (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clr     (clr_c),
      .step    (tick_c),
      .load    (load_c),
      .value   (chan_val_c[n]),
      .pdm_bit (pdm_bits[n])
    );
  end

  assign pdm_out     = pdm_bits;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pdm_modulator_4ch.sv
// Bench for pdm_modulator_4ch at W=4: one instance steps every aclk, one every 3 aclk.
module tb_pdm_modulator_4ch;

  localparam int unsigned W = 4;

  logic         aclk;
  logic         aresetn;
  logic         enable;
  logic [W-1:0] ch1, ch2, ch3, ch4;
  logic [3:0]   pdm1, pdm3;
  logic         fs1, fs3;

  int checks = 0;
  int errors = 0;

  pdm_modulator_4ch #(.PDM_VALUE_WIDTH(W), .CLK_DIV(1)) dut1 (
    .aclk (aclk), .aresetn (aresetn), .enable (enable),
    .pdm_channel_1 (ch1), .pdm_channel_2 (ch2),
    .pdm_channel_3 (ch3), .pdm_channel_4 (ch4),
    .pdm_out (pdm1), .frame_start (fs1)
  );

  pdm_modulator_4ch #(.PDM_VALUE_WIDTH(W), .CLK_DIV(3)) dut3 (
    .aclk (aclk), .aresetn (aresetn), .enable (enable),
    .pdm_channel_1 (ch1), .pdm_channel_2 (ch2),
    .pdm_channel_3 (ch3), .pdm_channel_4 (ch4),
    .pdm_out (pdm3), .frame_start (fs3)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [3:0] v1, v2, v3, v4;   // channel values
    logic [4:0] e1, e2, e3, e4;   // expected ones per 16-step frame
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ch(input vec_t v);
    ch1 = v.v1; ch2 = v.v2; ch3 = v.v3; ch4 = v.v4;
  endtask

  initial begin
    int   ones1 [4];
    int   ones3 [4];
    int   exp_c [4];
    int   vals  [4];
    logic [3:0] prev1;
    int   cnt_a, cnt_b;

    // {values, expected ones per frame}, computed by hand: density = value/16
    vecs[0] = '{v1:4'd5,  v2:4'd5,  v3:4'd5, v4:4'd5,  e1:5'd5,  e2:5'd5,  e3:5'd5, e4:5'd5};
    vecs[1] = '{v1:4'd0,  v2:4'd15, v3:4'd8, v4:4'd1,  e1:5'd0,  e2:5'd15, e3:5'd8, e4:5'd1};
    vecs[2] = '{v1:4'd3,  v2:4'd12, v3:4'd7, v4:4'd10, e1:5'd3,  e2:5'd12, e3:5'd7, e4:5'd10};
    vecs[3] = '{v1:4'd14, v2:4'd2,  v3:4'd6, v4:4'd9,  e1:5'd14, e2:5'd2,  e3:5'd6, e4:5'd9};

    aresetn = 1'b0; enable = 1'b0;
    ch1 = '0; ch2 = '0; ch3 = '0; ch4 = '0;
    repeat (2) @(negedge aclk);
    check("reset_pdm1", int'(pdm1), 0);
    check("reset_fs1",  int'(fs1),  0);
    check("reset_pdm3", int'(pdm3), 0);
    check("reset_fs3",  int'(fs3),  0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("idle_pdm1", int'(pdm1), 0);

    // Table-driven: density over full frames for both prescaler settings
    for (int i = 0; i < 4; i++) begin
      enable = 1'b0;
      set_ch(vecs[i]);
      @(negedge aclk);
      check("clear_pdm1", int'(pdm1), 0);
      vals  = '{int'(vecs[i].v1), int'(vecs[i].v2), int'(vecs[i].v3), int'(vecs[i].v4)};
      exp_c = '{int'(vecs[i].e1), int'(vecs[i].e2), int'(vecs[i].e3), int'(vecs[i].e4)};
      ones1 = '{0, 0, 0, 0};
      ones3 = '{0, 0, 0, 0};
      prev1 = '0;
      enable = 1'b1;
      for (int k = 1; k <= 51; k++) begin
        @(negedge aclk);
        if (k <= 49) check("fs1_period", int'(fs1), (k % 16 == 1) ? 1 : 0);
        check("fs3_period", int'(fs3), (k == 3 || k == 51) ? 1 : 0);
        for (int c = 0; c < 4; c++) begin
          if (k <= 16) begin
            ones1[c] += int'(pdm1[c]);
            if (vals[c] == 8 && k > 1)
              check("half_alternate", int'(pdm1[c] != prev1[c]), 1);
          end
          // each dut3 step is held for 3 cycles: k=3..50 covers 16 steps
          if (k >= 3 && k <= 50) ones3[c] += int'(pdm3[c]);
        end
        prev1 = pdm1;
      end
      for (int c = 0; c < 4; c++) begin
        check("ones_div1", ones1[c], exp_c[c]);
        check("ones_div3", ones3[c], 3 * exp_c[c]);
      end
    end

    // Mid-frame value change is deferred to the next frame boundary
    enable = 1'b0;
    set_ch('{v1:4'd3, v2:4'd0, v3:4'd0, v4:4'd0, e1:5'd0, e2:5'd0, e3:5'd0, e4:5'd0});
    @(negedge aclk);
    enable = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge aclk);
      if (k <= 16) cnt_a += int'(pdm1[0]);
      else         cnt_b += int'(pdm1[0]);
      if (k == 7)  ch1 = 4'd12;
      if (k == 17) check("latch_fs", int'(fs1), 1);
    end
    check("change_old_frame", cnt_a, 3);
    check("change_new_frame", cnt_b, 12);

    // enable drop mid-frame, then restart
    enable = 1'b0;
    set_ch('{v1:4'd7, v2:4'd9, v3:4'd11, v4:4'd13, e1:5'd0, e2:5'd0, e3:5'd0, e4:5'd0});
    @(negedge aclk);
    enable = 1'b1;
    repeat (9) @(negedge aclk);
    enable = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge aclk);
      check("dis_pdm1", int'(pdm1), 0);
      check("dis_fs1",  int'(fs1),  0);
      check("dis_fs3",  int'(fs3),  0);
    end
    enable = 1'b1;
    ones1 = '{0, 0, 0, 0};
    for (int k = 1; k <= 16; k++) begin
      @(negedge aclk);
      if (k == 1) check("reen_fs1", int'(fs1), 1);
      for (int c = 0; c < 4; c++) ones1[c] += int'(pdm1[c]);
    end
    check("reen_ones_ch1", ones1[0], 7);
    check("reen_ones_ch2", ones1[1], 9);
    check("reen_ones_ch3", ones1[2], 11);
    check("reen_ones_ch4", ones1[3], 13);

    // Asynchronous reset between clock edges
    enable = 1'b0;
    set_ch('{v1:4'd15, v2:4'd15, v3:4'd15, v4:4'd15, e1:5'd0, e2:5'd0, e3:5'd0, e4:5'd0});
    @(negedge aclk);
    enable = 1'b1;
    @(negedge aclk);
    @(posedge aclk);
    #2;
    check("pre_async_pdm1", int'(pdm1), 15);
    aresetn = 1'b0;
    #1;
    check("async_pdm1", int'(pdm1), 0);
    check("async_pdm3", int'(pdm3), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #2;
    check("pre_async_fs1", int'(fs1), 1);
    aresetn = 1'b0;
    #1;
    check("async_fs1", int'(fs1), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    enable = 1'b0;
    @(negedge aclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
